// File: rtl/fact_bus_if.sv
// Bus front end for the factorial accelerator:
// operand latch, go/done handshake, sticky status.
module fact_bus_if #(
  parameter int DW      = 32,
  parameter int NW      = 4,
  parameter int MAX_N   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    a,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic [NW-1:0] fact_n,
  output logic          fact_go,
  output logic          fact_err,
  input  logic          fact_done,
  input  logic [DW-1:0] fact_result,
  output logic          busy
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_TERM = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [DW-1:0] res_q, res_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic n_wr;
  logic go_wr;

  assign n_wr  = we && (a == 2'd0);
  assign go_wr = we && (a == 2'd1) && wd[0];

  assign fact_n   = n_q;
  assign fact_err = 32'(n_q) > 32'(MAX_N);

  // Next-state and handshake outputs; operand frozen outside IDLE.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    fact_go = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (n_wr) n_d = wd[NW-1:0];
        if (go_wr) begin
          done_d = 1'b0;
          err_d  = fact_err;
          if (!fact_err) state_d = S_START;
        end
      end
      S_START: begin
        fact_go = 1'b1;
        busy    = 1'b1;
        wdog_d  = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        busy   = 1'b1;
        wdog_d = wdog_q + WW'(1);
        if (fact_done) begin
          res_d   = fact_result;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wdog_q == WD_TERM) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register read mux; unmapped bits read zero.
  always_comb begin
    rd = '0;
    unique case (a)
      2'd0: rd[NW-1:0] = n_q;
      2'd1: rd[0]      = busy;
      2'd2: rd[1:0]    = {err_q, done_q};
      2'd3: rd         = res_q;
      default: rd      = '0;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_fact_bus_if.sv
// Scoreboard bench for fact_bus_if: directed
// stimulus queues expectations, monitor compares.
module tb_fact_bus_if;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [1:0]    a;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic [3:0]    fact_n;
  logic          fact_go;
  logic          fact_err;
  logic          fact_done;
  logic [DW-1:0] fact_result;
  logic          busy;

  fact_bus_if dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .a(a),
    .wd(wd),
    .rd(rd),
    .fact_n(fact_n),
    .fact_go(fact_go),
    .fact_err(fact_err),
    .fact_done(fact_done),
    .fact_result(fact_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    go_cnt = 0;
  int    go_base = 0;
  int    lat = 0;
  logic  chk_v = 1'b0;

  // sel 0..3: rd at that address; 4 busy; 5 fact_err;
  // 6 go pulses since base; 7 fact_n; 8 latency; 9 fact_go
  function automatic logic [31:0] probe(int sel);
    case (sel)
      0, 1, 2, 3: return rd;
      4: return {31'b0, busy};
      5: return {31'b0, fact_err};
      6: return 32'(go_cnt - go_base);
      7: return {28'b0, fact_n};
      8: return 32'(lat);
      9: return {31'b0, fact_go};
      default: return 32'hdead_beef;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (fact_go) go_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_v) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty");
      end else begin
        item_t it;
        logic [31:0] act;
        it  = sbq.pop_front();
        act = probe(it.sel);
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d",
                   it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [1:0] addr, logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic pulse_done(logic [31:0] res);
    fact_result = res;
    fact_done   = 1'b1;
    tick(1);
    fact_done   = 1'b0;
  endtask

  task automatic chk(int sel, logic [31:0] exp, string name);
    item_t it;
    int    s;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    sbq.push_back(it);
    s = sel;
    if (sel < 4) a = s[1:0];
    chk_v = 1'b1;
    @(negedge clk);
    #1 chk_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    we = 1'b0;
    a = 2'd0;
    wd = '0;
    fact_done = 1'b0;
    fact_result = '0;
    tick(2);
    chk(4, 0, "rst_busy");
    chk(2, 0, "rst_status");
    chk(3, 0, "rst_result");
    rst = 1'b0;
    chk(0, 0, "rst_n");
    chk(5, 0, "rst_ferr");

    // reset while busy abandons the transaction
    wr(0, 5);
    wr(1, 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk(4, 0, "mid_rst_busy");
    chk(2, 0, "mid_rst_status");
    chk(3, 0, "mid_rst_result");
    chk(0, 0, "mid_rst_n");
    pulse_done(77);
    chk(2, 0, "late_done_status");
    chk(3, 0, "late_done_result");

    // normal run: 5! = 120
    wr(0, 5);
    go_base = go_cnt;
    wr(1, 1);
    chk(9, 1, "go_start");
    chk(9, 0, "go_drop");
    chk(4, 1, "busy_run");
    chk(1, 1, "go_reg_busy");
    tick(6);
    pulse_done(120);
    chk(2, 1, "norm_status");
    chk(3, 120, "norm_result");
    chk(4, 0, "norm_idle");
    chk(6, 1, "norm_go_count");

    // invalid operand, then recover with 4! = 24
    wr(0, 13);
    chk(5, 1, "ferr_13");
    chk(7, 13, "fact_n_13");
    go_base = go_cnt;
    wr(1, 1);
    chk(2, 2, "inv_status");
    chk(4, 0, "inv_busy");
    chk(6, 0, "inv_no_go");
    wr(0, 12);
    chk(5, 0, "ferr_12");
    wr(0, 4);
    wr(1, 1);
    chk(2, 0, "clr_status");
    tick(3);
    pulse_done(24);
    chk(2, 1, "rec_status");
    chk(3, 24, "rec_result");

    // non-start and read-only writes
    wr(1, 2);
    chk(4, 0, "go0_busy");
    chk(2, 1, "go0_status");
    wr(2, 3);
    chk(2, 1, "status_wr");
    wr(3, 5);
    chk(3, 24, "result_wr");

    // writes during BUSY are ignored
    wr(0, 5);
    go_base = go_cnt;
    wr(1, 1);
    tick(1);
    wr(0, 9);
    wr(1, 1);
    chk(0, 5, "n_hold");
    chk(2, 0, "busy_status");
    chk(6, 1, "one_go");
    pulse_done(120);
    chk(2, 1, "prot_status");
    chk(3, 120, "prot_result");
    chk(0, 5, "prot_n");

    // watchdog: no fact_done
    wr(1, 1);
    lat = 0;
    while (busy && lat < 200) begin
      tick(1);
      lat++;
    end
    chk(8, 65, "wd_busy_cycles");
    chk(2, 2, "wd_status");
    chk(3, 120, "wd_result");
    chk(4, 0, "wd_busy");

    // done on the terminal watchdog cycle wins
    wr(1, 1);
    tick(64);
    pulse_done(720);
    chk(2, 1, "race_status");
    chk(3, 720, "race_result");

    // N=0 is legal; N write keeps low bits only
    wr(0, 0);
    wr(1, 1);
    tick(3);
    pulse_done(1);
    chk(2, 1, "n0_status");
    chk(3, 1, "n0_result");
    wr(0, 32'h1f);
    chk(7, 15, "n_trunc");
    chk(5, 1, "ferr_15");

    tick(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
